// File: rtl/branch_resolution_unit.sv
// branch_resolution_unit: in-flight branch FIFO that checks predictions at resolve time,
// raises the registered flush/redirect and predictor update, and keeps saturating statistics.
module branch_resolution_unit #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             dec_valid,
    input  logic [31:0]      dec_pc,
    input  logic             dec_pred_taken,
    input  logic [31:0]      dec_pred_target,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    output logic             upd_valid,
    output logic             upd_taken,
    output logic [31:0]      upd_pc,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             full,
    output logic             err_overflow,
    output logic             err_underflow,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispredict_count
);
    localparam int AW = $clog2(DEPTH);

    logic [31:0]      r_pc  [DEPTH];
    logic             r_pt  [DEPTH];
    logic [31:0]      r_tgt [DEPTH];
    logic [AW-1:0]    r_head, r_tail;
    logic [AW:0]      r_count;
    logic             r_upd_valid, r_upd_taken, r_flush, r_ovf, r_unf;
    logic [31:0]      r_upd_pc, r_redirect;
    logic [CNT_W-1:0] r_br_cnt, r_mis_cnt;

    logic             w_full, w_empty, w_pop, w_mis, w_push, w_ovf;
    logic [31:0]      w_redirect;

    assign w_full  = r_count == (AW+1)'(DEPTH);
    assign w_empty = r_count == '0;
    assign w_pop   = res_valid && !w_empty;
    assign w_mis   = w_pop && (res_taken != r_pt[r_head] ||
                               (res_taken && res_target != r_tgt[r_head]));
    // A push alongside a mispredicted pop is wrong-path and simply vanishes.
    assign w_push  = dec_valid && !w_full && !w_mis;
    assign w_ovf   = dec_valid && w_full && !w_mis;
    assign w_redirect = res_taken ? res_target : r_pc[r_head] + 32'd4;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_tail]  <= dec_pc;
            r_pt[r_tail]  <= dec_pred_taken;
            r_tgt[r_tail] <= dec_pred_target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_upd_valid <= 1'b0;
            r_upd_taken <= 1'b0;
            r_upd_pc    <= '0;
            r_flush     <= 1'b0;
            r_redirect  <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
            r_br_cnt    <= '0;
            r_mis_cnt   <= '0;
        end else begin
            r_upd_valid <= w_pop;
            r_flush     <= w_mis;
            if (w_pop) begin
                r_upd_taken <= res_taken;
                r_upd_pc    <= r_pc[r_head];
            end
            if (w_mis) begin
                r_redirect <= w_redirect;
                r_head     <= r_head + AW'(1);
                r_tail     <= r_head + AW'(1);
                r_count    <= '0;
            end else begin
                r_head  <= r_head + AW'(w_pop);
                r_tail  <= r_tail + AW'(w_push);
                r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
            end
            if (w_ovf)
                r_ovf <= 1'b1;
            if (res_valid && w_empty)
                r_unf <= 1'b1;
            if (w_pop && !(&r_br_cnt))
                r_br_cnt <= r_br_cnt + CNT_W'(1);
            if (w_mis && !(&r_mis_cnt))
                r_mis_cnt <= r_mis_cnt + CNT_W'(1);
        end
    end

    assign upd_valid        = r_upd_valid;
    assign upd_taken        = r_upd_taken;
    assign upd_pc           = r_upd_pc;
    assign flush            = r_flush;
    assign redirect_pc      = r_redirect;
    assign full             = w_full;
    assign err_overflow     = r_ovf;
    assign err_underflow    = r_unf;
    assign branch_count     = r_br_cnt;
    assign mispredict_count = r_mis_cnt;
endmodule

// File: tb/tb_branch_resolution_unit.sv
// tb_branch_resolution_unit: directed and random stimulus against a queue-based model;
// a second instance with 4-bit counters exercises statistic saturation.
module tb_branch_resolution_unit;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dec_valid = 1'b0, dec_pred_taken = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
    logic [31:0] dec_pc = '0, dec_pred_target = '0, res_target = '0;

    logic        a_upd_valid, a_upd_taken, a_flush, a_full, a_ovf, a_unf;
    logic [31:0] a_upd_pc, a_redir;
    logic [15:0] a_bc, a_mc;
    logic        b_upd_valid, b_upd_taken, b_flush, b_full, b_ovf, b_unf;
    logic [31:0] b_upd_pc, b_redir;
    logic [3:0]  b_bc, b_mc;

    branch_resolution_unit #(.DEPTH(DEPTH), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_pc(dec_pc),
        .dec_pred_taken(dec_pred_taken), .dec_pred_target(dec_pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(a_upd_valid), .upd_taken(a_upd_taken), .upd_pc(a_upd_pc),
        .flush(a_flush), .redirect_pc(a_redir), .full(a_full),
        .err_overflow(a_ovf), .err_underflow(a_unf),
        .branch_count(a_bc), .mispredict_count(a_mc)
    );

    branch_resolution_unit #(.DEPTH(DEPTH), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .dec_pc(dec_pc),
        .dec_pred_taken(dec_pred_taken), .dec_pred_target(dec_pred_target),
        .res_valid(res_valid), .res_taken(res_taken), .res_target(res_target),
        .upd_valid(b_upd_valid), .upd_taken(b_upd_taken), .upd_pc(b_upd_pc),
        .flush(b_flush), .redirect_pc(b_redir), .full(b_full),
        .err_overflow(b_ovf), .err_underflow(b_unf),
        .branch_count(b_bc), .mispredict_count(b_mc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        bit          pt;
        logic [31:0] tgt;
    } ent_t;

    ent_t        q[$];
    int          n_br, n_mis, checks, errors;
    bit          e_upd, e_taken, e_flush, e_ovf, e_unf;
    logic [31:0] e_pc, e_redir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int n, input int w);
        return n > (1 << w) - 1 ? (1 << w) - 1 : n;
    endfunction

    task automatic model_reset();
        q.delete();
        n_br = 0;
        n_mis = 0;
        {e_upd, e_taken, e_flush, e_ovf, e_unf} = '0;
    endtask

    task automatic check_all();
        check("upd_valid", a_upd_valid, e_upd);
        check("flush", a_flush, e_flush);
        if (e_upd) begin
            check("upd_taken", a_upd_taken, e_taken);
            check("upd_pc", a_upd_pc, e_pc);
        end
        if (e_flush)
            check("redirect_pc", a_redir, e_redir);
        check("full", a_full, q.size() == DEPTH);
        check("err_overflow", a_ovf, e_ovf);
        check("err_underflow", a_unf, e_unf);
        check("branch_count", a_bc, sat(n_br, 16));
        check("mispredict_count", a_mc, sat(n_mis, 16));
        check("b_branch_count", b_bc, sat(n_br, 4));
        check("b_mispredict_count", b_mc, sat(n_mis, 4));
        check("b_flush", b_flush, e_flush);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_upd_valid"}, a_upd_valid, 0);
        check({tag, "_upd_taken"}, a_upd_taken, 0);
        check({tag, "_upd_pc"}, a_upd_pc, 0);
        check({tag, "_flush"}, a_flush, 0);
        check({tag, "_redirect"}, a_redir, 0);
        check({tag, "_full"}, a_full, 0);
        check({tag, "_ovf"}, a_ovf, 0);
        check({tag, "_unf"}, a_unf, 0);
        check({tag, "_bc"}, a_bc, 0);
        check({tag, "_mc"}, a_mc, 0);
        check({tag, "_b_bc"}, b_bc, 0);
        check({tag, "_b_upd_valid"}, b_upd_valid, 0);
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit dv, input logic [31:0] pc, input bit pt, input logic [31:0] tgt,
                        input bit rv, input bit rt, input logic [31:0] rtgt);
        bit   was_full, mis;
        ent_t h;
        dec_valid = dv; dec_pc = pc; dec_pred_taken = pt; dec_pred_target = tgt;
        res_valid = rv; res_taken = rt; res_target = rtgt;
        was_full = q.size() == DEPTH;
        mis = 0;
        e_upd = 0;
        e_flush = 0;
        if (rv) begin
            if (q.size() == 0) e_unf = 1;
            else begin
                h = q.pop_front();
                mis = (rt != h.pt) || (rt && rtgt != h.tgt);
                e_upd = 1;
                e_taken = rt;
                e_pc = h.pc;
                n_br++;
                if (mis) begin
                    n_mis++;
                    e_flush = 1;
                    e_redir = rt ? rtgt : h.pc + 32'd4;
                    q.delete();
                end
            end
        end
        if (dv && !mis) begin
            if (was_full) e_ovf = 1;
            else q.push_back('{pc, pt, tgt});
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic push(input logic [31:0] pc, input bit pt, input logic [31:0] tgt);
        step(1, pc, pt, tgt, 0, 0, 0);
    endtask

    task automatic resolve(input bit rt, input logic [31:0] rtgt);
        step(0, 0, 0, 0, 1, rt, rtgt);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        // reset held with random inputs
        repeat (3) begin
            dec_valid = 1'($urandom); dec_pc = $urandom; dec_pred_taken = 1'($urandom);
            dec_pred_target = $urandom; res_valid = 1'($urandom); res_taken = 1'($urandom);
            res_target = $urandom;
            @(negedge clk);
            check_zero("rst");
        end
        {dec_valid, res_valid} = '0;
        rst_n = 1'b1;

        push(32'h100, 1, 32'h140);
        idle();
        resolve(1, 32'h140);
        idle();

        push(32'h200, 1, 32'h240);
        idle();
        resolve(1, 32'h240);
        idle();

        push(32'h300, 1, 32'h380);
        push(32'h310, 0, 32'h390);
        push(32'h320, 1, 32'h3a0);
        resolve(0, 32'h0);
        idle();
        check("mis_redirect", a_redir, 32'h304);

        push(32'hFFFFFFFC, 1, 32'h1000);
        step(1, 32'h500, 1, 32'h540, 1, 0, 32'h0);
        check("wrap_redirect", a_redir, 32'h0);
        check("wrap_no_ovf", a_ovf, 0);
        resolve(1, 32'h540);
        check("underflow", a_unf, 1);
        idle();

        for (int i = 0; i < 5; i++) push(32'h600 + 32'(i * 16), 0, 32'h700);
        check("overflow", a_ovf, 1);
        for (int i = 0; i < 4; i++) begin
            resolve(0, 32'h0);
            idle();
        end
        check("drained_full", a_full, 0);

        // random traffic, honouring the bubble after each resolution
        for (int i = 0; i < 400; i++) begin
            bit          rv, rt;
            logic [31:0] rtgt;
            rv = !e_upd && ($urandom_range(0, 2) == 0);
            rt = 1'($urandom);
            rtgt = (q.size() > 0 && $urandom_range(0, 3) != 0) ? q[0].tgt : 32'($urandom_range(0, 1)) << 6;
            step($urandom_range(0, 2) != 0, $urandom & 32'hFFFFFFFC, 1'($urandom),
                 32'($urandom_range(0, 1)) << 6, rv, rt, rtgt);
        end

        // asynchronous reset in the middle of a resolve
        push(32'h800, 1, 32'h840);
        res_valid = 1'b1; res_taken = 1'b0; dec_valid = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_zero("async");
        @(negedge clk);
        {dec_valid, res_valid} = '0;
        rst_n = 1'b1;
        model_reset();

        for (int i = 0; i < 17; i++) begin
            push(32'h1000 + 32'(i * 4), 1, 32'h2000);
            resolve(1, 32'h2000);
        end
        check("sat_b_bc", b_bc, 15);
        check("sat_a_bc", a_bc, 17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
